// File: rtl/spi_master_if.sv
// Controller-side byte handshake plus SPI pins for spi_master.
// The master modport is the SPI master's view; slave is the controller/peripheral side.
interface spi_master_if;
    logic       i_TX_DV;
    logic [7:0] i_TX_Byte;
    logic       i_TX_Last;
    logic       o_TX_Ready;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_SPI_Clk;
    logic       i_SPI_MISO;
    logic       o_SPI_MOSI;
    logic       o_SPI_CS_n;

    modport master (
        input  i_TX_DV, i_TX_Byte, i_TX_Last, i_SPI_MISO,
        output o_TX_Ready, o_RX_DV, o_RX_Byte, o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );

    modport slave (
        output i_TX_DV, i_TX_Byte, i_TX_Last, i_SPI_MISO,
        input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );
endinterface

// File: rtl/spi_master.sv
// Byte-oriented SPI master, modes 0-3, with multi-byte transactions that keep
// CS_n low until a byte flagged "last" completes. All outputs are registered.
module spi_master #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_INACTIVE_CLKS  = 4
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    spi_master_if.master bus
);
    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam int   HW   = $clog2(CLKS_PER_HALF_BIT);
    localparam int   GW   = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [GW-1:0] G_LAST = GW'(CS_INACTIVE_CLKS - 1);

    typedef enum logic [2:0] {IDLE, XFER, WAIT_NEXT, CS_HOLD, CS_GAP} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [4:0]    ecnt_q, ecnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [7:0]    tx_sr_q, tx_sr_d;
    logic [7:0]    rx_sr_q, rx_sr_d;
    logic          last_q, last_d;
    logic          ready_q, ready_d;
    logic          rx_dv_q, rx_dv_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_n_q, cs_n_d;
    logic          leading;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            hcnt_q    <= '0;
            ecnt_q    <= '0;
            gcnt_q    <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            last_q    <= 1'b0;
            ready_q   <= 1'b1;
            rx_dv_q   <= 1'b0;
            rx_byte_q <= '0;
            sclk_q    <= CPOL;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            ecnt_q    <= ecnt_d;
            gcnt_q    <= gcnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            last_q    <= last_d;
            ready_q   <= ready_d;
            rx_dv_q   <= rx_dv_d;
            rx_byte_q <= rx_byte_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        ecnt_d    = ecnt_q;
        gcnt_d    = gcnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        last_d    = last_q;
        ready_d   = ready_q;
        rx_dv_d   = 1'b0;
        rx_byte_d = rx_byte_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        leading   = 1'b0;

        case (state_q)
            IDLE, WAIT_NEXT: begin
                if (bus.i_TX_DV && ready_q) begin
                    state_d = XFER;
                    ready_d = 1'b0;
                    cs_n_d  = 1'b0;
                    tx_sr_d = bus.i_TX_Byte;
                    last_d  = bus.i_TX_Last;
                    hcnt_d  = '0;
                    ecnt_d  = '0;
                    if (!CPHA) mosi_d = bus.i_TX_Byte[7];
                end
            end
            XFER: begin
                hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
                if (ecnt_q == 5'd16) begin
                    rx_dv_d   = 1'b1;
                    rx_byte_d = rx_sr_q;
                    if (last_q) begin
                        state_d = CS_HOLD;
                    end else begin
                        state_d = WAIT_NEXT;
                        ready_d = 1'b1;
                    end
                end else if (hcnt_q == H_LAST) begin
                    // Edge number is ecnt_q+1: odd edges lead, even edges trail.
                    ecnt_d  = ecnt_q + 5'd1;
                    sclk_d  = ~sclk_q;
                    leading = ~ecnt_q[0];
                    if (leading == !CPHA) rx_sr_d = {rx_sr_q[6:0], bus.i_SPI_MISO};
                    if (CPHA && leading) begin
                        mosi_d  = tx_sr_q[7];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end else if (!CPHA && !leading && ecnt_q != 5'd15) begin
                        mosi_d  = tx_sr_q[6];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end
            end
            CS_HOLD: begin
                hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
                if (hcnt_q == H_LAST) begin
                    state_d = CS_GAP;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    gcnt_d  = '0;
                end
            end
            CS_GAP: begin
                if (gcnt_q == G_LAST) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_TX_Ready = ready_q;
    assign bus.o_RX_DV    = rx_dv_q;
    assign bus.o_RX_Byte  = rx_byte_q;
    assign bus.o_SPI_Clk  = sclk_q;
    assign bus.o_SPI_MOSI = mosi_q;
    assign bus.o_SPI_CS_n = cs_n_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: four instances (modes 0,3,1,2) each with a bit-level
// SPI slave model; RX bytes and slave-captured MOSI bytes are scoreboarded.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int t0 = 0;

    logic [3:0] tx_dv = '0;
    logic [7:0] tx_byte = '0;
    logic       tx_last = 1'b0;
    wire  [3:0] ready, rx_dv, sclk, mosi, cs;
    wire  [7:0] rx_byte [4];

    logic [7:0] slv_next [4];
    logic [7:0] exp_rx   [4][$];
    logic [7:0] exp_mosi [4][$];

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut%0d got=%0h expected=%0h", nm, d, got, exp);
        end
    endtask

    for (genvar i = 0; i < 4; i++) begin : g
        localparam int   M  = (i == 0) ? 0 : (i == 1) ? 3 : (i == 2) ? 1 : 2;
        localparam int   HH = (i == 0) ? 2 : (i == 1) ? 4 : 3;
        localparam logic CP = (M >= 2);
        localparam logic CA = (M == 1) || (M == 3);

        spi_master_if ifc ();
        logic       miso;
        logic       p_clk = 1'bx;
        logic       p_cs = 1'bx;
        logic       s_out = 1'b0;
        logic [7:0] s_sh = '0;
        logic [7:0] s_rx = '0;
        int         s_bits = 0;
        int         edges = 0;
        int         last_edges = 0;
        int         rises = 0;

        assign ifc.i_TX_DV    = tx_dv[i];
        assign ifc.i_TX_Byte  = tx_byte;
        assign ifc.i_TX_Last  = tx_last;
        assign ifc.i_SPI_MISO = miso;
        assign ready[i]   = ifc.o_TX_Ready;
        assign rx_dv[i]   = ifc.o_RX_DV;
        assign rx_byte[i] = ifc.o_RX_Byte;
        assign sclk[i]    = ifc.o_SPI_Clk;
        assign mosi[i]    = ifc.o_SPI_MOSI;
        assign cs[i]      = ifc.o_SPI_CS_n;

        spi_master #(.SPI_MODE(M), .CLKS_PER_HALF_BIT(HH), .CS_INACTIVE_CLKS(4)) dut (
            .i_Clk (clk),
            .i_Rst (rst),
            .bus   (ifc.master)
        );

        always @* miso = CA ? s_out : ((s_bits == 0) ? slv_next[i][7] : s_sh[7]);

        always @(ifc.o_SPI_Clk or ifc.o_SPI_CS_n) begin
            if (ifc.o_SPI_CS_n !== 1'b0) begin
                if (p_cs === 1'b0) begin
                    last_edges = edges;
                    rises++;
                end
                edges  = 0;
                s_bits = 0;
            end else if (ifc.o_SPI_Clk !== p_clk) begin
                edges++;
                if (ifc.o_SPI_Clk !== CP) begin
                    if (s_bits == 0) s_sh = slv_next[i];
                    if (!CA) begin
                        s_rx = {s_rx[6:0], ifc.o_SPI_MOSI};
                        s_bits++;
                    end else begin
                        s_out = s_sh[7];
                        s_sh  = s_sh << 1;
                    end
                end else begin
                    if (!CA) s_sh = s_sh << 1;
                    else begin
                        s_rx = {s_rx[6:0], ifc.o_SPI_MOSI};
                        s_bits++;
                    end
                    if (s_bits == 8) begin
                        s_bits = 0;
                        if (exp_mosi[i].size() == 0) begin
                            tests++; fails++;
                            $display("FAIL mosi_unexpected dut%0d got=%0h", i, s_rx);
                        end else chk("mosi_byte", i, 32'(s_rx), 32'(exp_mosi[i].pop_front()));
                    end
                end
            end
            p_clk = ifc.o_SPI_Clk;
            p_cs  = ifc.o_SPI_CS_n;
        end

        always @(negedge clk) begin
            if (ifc.o_RX_DV === 1'b1) begin
                if (exp_rx[i].size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rx_unexpected dut%0d got=%0h", i, ifc.o_RX_Byte);
                end else chk("rx_byte", i, 32'(ifc.o_RX_Byte), 32'(exp_rx[i].pop_front()));
            end
        end
    end

    function automatic logic cpol(input int d);
        return (d == 1) || (d == 3);
    endfunction

    function automatic int get_edges(input int d);
        case (d)
            0: return g[0].last_edges;
            1: return g[1].last_edges;
            2: return g[2].last_edges;
            default: return g[3].last_edges;
        endcase
    endfunction

    function automatic int get_rises(input int d);
        case (d)
            0: return g[0].rises;
            1: return g[1].rises;
            2: return g[2].rises;
            default: return g[3].rises;
        endcase
    endfunction

    task automatic wait_ready(input int d);
        int n = 0;
        while (ready[d] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        if (ready[d] !== 1'b1) begin
            tests++; fails++;
            $display("FAIL ready_timeout dut%0d got=%b expected=1", d, ready[d]);
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (!(ready[d] === 1'b1 && cs[d] === 1'b1) && n < 600) begin @(negedge clk); n++; end
        if (!(ready[d] === 1'b1 && cs[d] === 1'b1)) begin
            tests++; fails++;
            $display("FAIL idle_timeout dut%0d ready=%b cs=%b expected 1/1", d, ready[d], cs[d]);
        end
    endtask

    task automatic send(input int d, input logic [7:0] b, input logic lst, input logic [7:0] rep, input bit push);
        wait_ready(d);
        chk("sclk_idle", d, 32'(sclk[d]), 32'(cpol(d)));
        slv_next[d] = rep;
        if (push) begin
            exp_rx[d].push_back(rep);
            exp_mosi[d].push_back(b);
        end
        tx_byte  = b;
        tx_last  = lst;
        tx_dv[d] = 1'b1;
        @(negedge clk);
        tx_dv[d] = 1'b0;
        t0 = cyc;
    endtask

    typedef struct {
        int         d;
        logic [7:0] tx;
        logic       last;
        logic [7:0] reply;
    } vec_t;

    initial begin
        vec_t tbl [8];
        int   nb, r0, rel, cs_hi, rx_at, nrx, rdy_at, gap;
        bit   seen_hi, drop, done;

        // mode3 burst, modes 1/2 single bytes, mode0 extremes and a mode0 burst
        tbl[0] = '{1, 8'h12, 1'b0, 8'h81};
        tbl[1] = '{1, 8'hF0, 1'b1, 8'h7E};
        tbl[2] = '{2, 8'h96, 1'b1, 8'h69};
        tbl[3] = '{3, 8'h96, 1'b1, 8'h3C};
        tbl[4] = '{0, 8'h00, 1'b1, 8'hFF};
        tbl[5] = '{0, 8'hFF, 1'b1, 8'h00};
        tbl[6] = '{0, 8'h5A, 1'b0, 8'h11};
        tbl[7] = '{0, 8'h3C, 1'b1, 8'h22};
        for (int k = 0; k < 4; k++) slv_next[k] = 8'h00;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 0, 32'(ready), 32'hF);
        chk("rst_cs",    0, 32'(cs),    32'hF);
        chk("rst_sclk",  0, 32'(sclk),  32'hA);
        chk("rst_mosi",  0, 32'(mosi),  32'h0);
        chk("rst_rxdv",  0, 32'(rx_dv), 32'h0);
        chk("rst_rxbyte", 0, 32'(rx_byte[0]), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // mode 0, H=2: single byte timing
        send(0, 8'hA5, 1'b1, 8'h3C, 1'b1);
        chk("ready_drop", 0, 32'(ready[0]), 32'h0);
        cs_hi = -1; rx_at = -1; nrx = 0; rdy_at = -1;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(negedge clk);
            rel = cyc - t0;
            if (cs[0] === 1'b1 && cs_hi < 0) cs_hi = rel;
            if (rx_dv[0] === 1'b1) begin nrx++; rx_at = rel; end
            if (ready[0] === 1'b1 && rdy_at < 0) rdy_at = rel;
        end
        chk("cs_rise_cycle", 0, 32'(cs_hi), 32'd34);
        chk("rx_dv_cycle",   0, 32'(rx_at), 32'd33);
        chk("rx_dv_count",   0, 32'(nrx),   32'd1);
        chk("ready_cycle",   0, 32'(rdy_at), 32'd38);
        chk("edges_single",  0, 32'(get_edges(0)), 32'd16);

        nb = 0; r0 = 0;
        for (int k = 0; k < 8; k++) begin
            if (nb == 0) r0 = get_rises(tbl[k].d);
            send(tbl[k].d, tbl[k].tx, tbl[k].last, tbl[k].reply, 1'b1);
            nb++;
            if (tbl[k].last) begin
                wait_idle(tbl[k].d);
                chk("edges_txn", tbl[k].d, 32'(get_edges(tbl[k].d)), 32'(16 * nb));
                chk("cs_rises",  tbl[k].d, 32'(get_rises(tbl[k].d)), 32'(r0 + 1));
                nb = 0;
            end
        end

        // TX_DV pulses while busy must be ignored
        send(0, 8'hC3, 1'b1, 8'h5A, 1'b1);
        while (cyc < t0 + 5) @(negedge clk);
        tx_byte = 8'hFF; tx_dv[0] = 1'b1;
        @(negedge clk);
        tx_dv[0] = 1'b0;
        while (cyc < t0 + 20) @(negedge clk);
        tx_dv[0] = 1'b1;
        @(negedge clk);
        tx_dv[0] = 1'b0;
        wait_idle(0);

        // reset in the middle of a byte
        send(0, 8'h77, 1'b1, 8'h99, 1'b0);
        while (cyc < t0 + 10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_cs",    0, 32'(cs[0]),    32'h1);
        chk("midrst_sclk",  0, 32'(sclk[0]),  32'h0);
        chk("midrst_mosi",  0, 32'(mosi[0]),  32'h0);
        chk("midrst_ready", 0, 32'(ready[0]), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_rxdv",  0, 32'(rx_dv[0]), 32'h0);
        send(0, 8'h5A, 1'b1, 8'hA3, 1'b1);
        wait_idle(0);

        // back-to-back transactions with TX_DV already high when Ready rises
        send(0, 8'h11, 1'b1, 8'hE7, 1'b1);
        while (cyc < t0 + 3) @(negedge clk);
        slv_next[0] = 8'h4D;
        exp_rx[0].push_back(8'h4D);
        exp_mosi[0].push_back(8'hB2);
        tx_byte = 8'hB2; tx_last = 1'b1; tx_dv[0] = 1'b1;
        seen_hi = 0; drop = 0; done = 0; gap = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (drop) tx_dv[0] = 1'b0;
            if (cs[0] === 1'b1) begin gap++; seen_hi = 1; end
            else if (seen_hi) done = 1;
            if (seen_hi && ready[0] === 1'b1) drop = 1;
        end
        tx_dv[0] = 1'b0;
        chk("cs_gap_cycles", 0, 32'(gap), 32'd5);
        wait_idle(0);

        for (int d = 0; d < 4; d++) begin
            wait_idle(d);
            chk("rx_pending",   d, 32'(exp_rx[d].size()),   32'd0);
            chk("mosi_pending", d, 32'(exp_mosi[d].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-oriented SPI master that serializes bytes onto MOSI and deserializes MISO, generating SCLK and an active-low chip select.
- Supports SPI modes 0-3 and multi-byte transactions; CS_n stays low between bytes until a byte flagged "last" completes.
- Sits between an internal controller (single-cycle valid/ready byte interface) and an off-chip or on-chip SPI slave.

Parameters:
- SPI_MODE, 0, SPI mode 0-3; CPOL = mode 2 or 3, CPHA = mode 1 or 3.
- CLKS_PER_HALF_BIT, 2, i_Clk cycles per SCLK half-period (H); must be at least 2.
- CS_INACTIVE_CLKS, 4, minimum i_Clk cycles CS_n stays high between transactions; must be at least 1.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset; one clock, asynchronous, active-high.
- i_TX_DV  in  1  one-cycle pulse; accepts i_TX_Byte and i_TX_Last when o_TX_Ready=1.
- i_TX_Byte  in  8  byte to send, MSb first.
- i_TX_Last  in  1  1 = deassert CS_n after this byte.
- o_TX_Ready  out  1  master can accept a byte.
- o_RX_DV  out  1  one-cycle pulse; o_RX_Byte is valid.
- o_RX_Byte  out  8  byte received on MISO, MSb first.
- o_SPI_Clk  out  1  SCLK.
- i_SPI_MISO  in  1  serial data from slave.
- o_SPI_MOSI  out  1  serial data to slave.
- o_SPI_CS_n  out  1  active-low chip select.

Behaviour:
- All outputs are registered.
- Reset values: o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=0x00, o_SPI_Clk=CPOL, o_SPI_MOSI=0, o_SPI_CS_n=1, state IDLE.
- Reset asserted mid-transfer: these values apply immediately and the partial byte is discarded; no o_RX_DV.
- States:
  - IDLE: CS_n=1, Ready=1.
  - XFER: Ready=0.
  - WAIT_NEXT: CS_n=0, SCLK=CPOL, Ready=1.
  - CS_HOLD: Ready=0.
  - CS_GAP: CS_n=1, Ready=0.
- Accept: i_TX_DV=1 while o_TX_Ready=1 in IDLE or WAIT_NEXT. Call the accepting edge T0.
  - At T0: latch byte and last flag, CS_n=0, Ready=0, go to XFER.
  - If CPHA=0, MOSI=bit7 at T0.
- i_TX_DV while o_TX_Ready=0 is ignored; no side effects.
- SCLK edges: edge k (k=1..16) toggles o_SPI_Clk at T0+k*H.
  - Odd edges are leading, even edges are trailing.
  - SCLK returns to CPOL after edge 16.
- CPHA=0:
  - MISO sampled at leading edges (the i_Clk edge that registers the toggle).
  - MOSI updated to the next bit at trailing edges 2,4,...,14.
- CPHA=1:
  - MOSI updated to bit7..bit0 at leading edges 1,3,...,15.
  - MISO sampled at trailing edges 2,...,16.
- MOSI holds its last value until the next byte starts or CS_n rises. When CS_n=1, MOSI=0.
- RX: o_RX_Byte updates and o_RX_DV=1 for exactly one cycle at T0+16H+1.
  - A pulse occurs for every byte, including the last.
- After edge 16 with last=0:
  - At T0+16H+1: WAIT_NEXT, o_TX_Ready=1, CS_n stays 0.
  - A new accept behaves as above, with CS_n unchanged.
  - No timeout in WAIT_NEXT.
- After edge 16 with last=1:
  - CS_HOLD for H cycles; CS_n=1 at T0+17H.
  - Then CS_GAP for CS_INACTIVE_CLKS cycles.
  - Then IDLE, Ready=1.
- i_TX_DV in the same cycle Ready rises is a valid accept; no bubble is required.
- Bit and half-bit counters wrap within a byte. A new byte reloads them; no residual counts carry between bytes.

Test Plan:
- Mode 0, H=2, send 0xA5 last=1, slave model returns 0x3C:
  - MOSI sampled on SCLK rising edges = 1,0,1,0,0,1,0,1.
  - o_RX_Byte=0x3C with a single o_RX_DV at T0+33.
  - CS_n low cycles T0..T0+33, high at T0+34; Ready=1 at T0+34+CS_INACTIVE_CLKS.
- Mode 3, H=4, burst 0x12 (last=0) then 0xF0 (last=1), accepted the cycle Ready rises; slave returns 0x81, 0x7E:
  - CS_n continuously low; 32 SCLK edges total.
  - Two o_RX_DV pulses with 0x81 then 0x7E.
  - SCLK idles high between bytes.
- Modes 1 and 2, H=3, byte 0x96 against a slave model in matching mode: each mode is bit-exact in both directions; SCLK idle level = CPOL.
- i_TX_DV pulsed at T0+5 and T0+20 during XFER with byte 0xFF: ignored, MOSI stream still original byte, no extra o_RX_DV.
- i_Rst asserted at T0+10 of a transfer:
  - CS_n=1, SCLK=CPOL, MOSI=0 in the same cycle; no o_RX_DV.
  - After release Ready=1, and a new 0x5A transfer completes correctly.
- Back-to-back transactions (last=1 each) with i_TX_DV held for the first Ready cycle: CS_n high for exactly CS_INACTIVE_CLKS+1 cycles between transactions.
